// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC fixed/float conversion stages.
// Holds the IEEE-754 single-precision field widths and the normaliser FSM state type.
package cordic_pkg;

    localparam int FP_EXP_BIAS = 127;
    localparam int FP_MANT_W   = 23;
    localparam int FP_EXP_W    = 8;
    localparam int FIX_W       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/cordic_fp_round.sv
// Round-to-nearest-even of a normalised 32-bit magnitude down to a 23-bit mantissa.
// The hidden bit (mag[31]) is not needed, so only mag[30:0] is passed in.
// A mantissa carry-out wraps the mantissa to zero and bumps the exponent.
module cordic_fp_round
    import cordic_pkg::*;
(
    input  logic [30:0]           mag,
    input  logic [FP_EXP_W-1:0]   exp_in,
    output logic [FP_MANT_W-1:0]  mant,
    output logic [FP_EXP_W-1:0]   exp_out
);

    logic             guard_s;
    logic             sticky_s;
    logic             lsb_s;
    logic             inc_s;
    logic [FP_MANT_W:0] sum_s;

    // Decide whether to round up and propagate any carry into the exponent
    always_comb begin
        guard_s  = mag[7];
        sticky_s = |mag[6:0];
        lsb_s    = mag[8];
        inc_s    = guard_s & (sticky_s | lsb_s);
        sum_s    = {1'b0, mag[30:8]} + {{FP_MANT_W{1'b0}}, inc_s};
        mant     = sum_s[FP_MANT_W-1:0];
        if (sum_s[FP_MANT_W]) begin
            exp_out = exp_in + 8'd1;
        end else begin
            exp_out = exp_in;
        end
    end

endmodule

// File: rtl/cordic_fix2float.sv
// Converts the signed fixed-point CORDIC result to an IEEE-754 single.
// Iterative normaliser: coarse shifts of COARSE_SHIFT bits, then single-bit
// shifts, then a pack cycle. Start/done handshake in custom-instruction style.
// Optional macro FIX2FLT_ROUND_NEAREST_EN selects round-to-nearest-even;
// without it the discarded low magnitude bits are truncated.
module cordic_fix2float
    import cordic_pkg::*;
#(
    parameter int FRAC_BITS    = 31,
    parameter int COARSE_SHIFT = 8
) (
    input  logic             clock,
    input  logic             aclr,
    input  logic             clk_en,
    input  logic             start,
    input  logic [FIX_W-1:0] dataa,
    output logic [31:0]      result,
    output logic             done
);

    localparam logic [FP_EXP_W-1:0] EXP_INIT   = FP_EXP_W'(FP_EXP_BIAS + FIX_W - 1 - FRAC_BITS);
    localparam logic [FP_EXP_W-1:0] COARSE_DEC = FP_EXP_W'(COARSE_SHIFT);

    fsm_state_t           state_r,  state_s;
    logic [FIX_W-1:0]     mag_r,    mag_s;
    logic [FP_EXP_W-1:0]  exp_r,    exp_s;
    logic                 sign_r,   sign_s;
    logic                 zero_r,   zero_s;
    logic [31:0]          result_r, result_s;
    logic                 done_r,   done_s;

    logic [FP_MANT_W-1:0] pack_mant_s;
    logic [FP_EXP_W-1:0]  pack_exp_s;

`ifdef FIX2FLT_ROUND_NEAREST_EN
    cordic_fp_round u_round (
        .mag     (mag_r[30:0]),
        .exp_in  (exp_r),
        .mant    (pack_mant_s),
        .exp_out (pack_exp_s)
    );
`else
    assign pack_mant_s = mag_r[30:8];
    assign pack_exp_s  = exp_r;
`endif

    // State and datapath registers; everything freezes while clk_en is low
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_r  <= IDLE;
            mag_r    <= 32'd0;
            exp_r    <= 8'd0;
            sign_r   <= 1'b0;
            zero_r   <= 1'b0;
            result_r <= 32'd0;
            done_r   <= 1'b0;
        end else if (clk_en) begin
            state_r  <= state_s;
            mag_r    <= mag_s;
            exp_r    <= exp_s;
            sign_r   <= sign_s;
            zero_r   <= zero_s;
            result_r <= result_s;
            done_r   <= done_s;
        end
    end

    // Next-state and datapath update: capture, normalise one step per edge, pack
    always_comb begin
        state_s  = state_r;
        mag_s    = mag_r;
        exp_s    = exp_r;
        sign_s   = sign_r;
        zero_s   = zero_r;
        result_s = result_r;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // The done cycle still belongs to the previous conversion,
                // so a start coinciding with done is not accepted.
                if (start && !done_r) begin
                    sign_s  = dataa[FIX_W-1];
                    mag_s   = dataa[FIX_W-1] ? (~dataa + 32'd1) : dataa;
                    exp_s   = EXP_INIT;
                    zero_s  = 1'b0;
                    state_s = NORM;
                end else begin
                    state_s = IDLE;
                end
            end
            NORM: begin
                if (mag_r == 32'd0) begin
                    zero_s  = 1'b1;
                    state_s = PACK;
                end else if (mag_r[FIX_W-1 -: COARSE_SHIFT] == '0) begin
                    mag_s = mag_r << COARSE_SHIFT;
                    exp_s = exp_r - COARSE_DEC;
                end else if (!mag_r[FIX_W-1]) begin
                    mag_s = mag_r << 1;
                    exp_s = exp_r - 8'd1;
                end else begin
                    state_s = PACK;
                end
            end
            PACK: begin
                if (zero_r) begin
                    result_s = 32'd0;
                end else begin
                    result_s = {sign_r, pack_exp_s, pack_mant_s};
                end
                done_s  = 1'b1;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign result = result_r;
    assign done   = done_r;

endmodule

// File: tb/tb_cordic_fix2float.sv
// Self-checking bench for cordic_fix2float: a table of directed vectors with
// hand-computed float results and latencies, followed by handshake corner cases
// (start while busy, start during done, clk_en freeze, aclr abort).
module tb_cordic_fix2float;

    logic        clock = 1'b0;
    logic        aclr;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FIX2FLT_ROUND_NEAREST_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef struct {
        logic [31:0] din;
        logic [31:0] res_trn;
        logic [31:0] res_rnd;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    cordic_fix2float dut (
        .clock  (clock),
        .aclr   (aclr),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .result (result),
        .done   (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Called #1 after an edge; returns #1 after the edge that sampled start
    task automatic pulse_start(input logic [31:0] d);
        start = 1'b1;
        dataa = d;
        @(posedge clock);
        #1;
        start = 1'b0;
        dataa = 32'hA5A5_A5A5;
    endtask

    // Counts edges until done is seen, bounded
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    // Counts done pulses over a fixed window
    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clock);
            #1;
            if (done === 1'b1) n++;
        end
    endtask

    initial begin
        int lat;
        int nd;
        int first_lat;
        logic [31:0] expv;

        vecs[0]  = '{32'h6EC1_BCCD, 32'h3F5D_8379, 32'h3F5D_837A, 3};
        vecs[1]  = '{32'h7FFF_FFFF, 32'h3F7F_FFFF, 32'h3F80_0000, 3};
        vecs[2]  = '{32'h8000_0000, 32'hBF80_0000, 32'hBF80_0000, 2};
        vecs[3]  = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 2};
        vecs[4]  = '{32'h0000_0001, 32'h3000_0000, 32'h3000_0000, 12};
        vecs[5]  = '{32'hC000_0000, 32'hBF00_0000, 32'hBF00_0000, 3};
        vecs[6]  = '{32'hFFFF_FFFF, 32'hB000_0000, 32'hB000_0000, 12};
        vecs[7]  = '{32'h0000_0100, 32'h3400_0000, 32'h3400_0000, 11};
        vecs[8]  = '{32'h1234_5678, 32'h3E11_A2B3, 32'h3E11_A2B4, 5};
        vecs[9]  = '{32'h4000_0040, 32'h3F00_0000, 32'h3F00_0000, 3};
        vecs[10] = '{32'h4000_00C0, 32'h3F00_0001, 32'h3F00_0002, 3};
        vecs[11] = '{32'h8000_0001, 32'hBF7F_FFFF, 32'hBF80_0000, 3};

        aclr   = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = 32'd0;
        #12;
        check("reset_result", result, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        @(posedge clock);
        #1;
        aclr = 1'b0;
        @(posedge clock);
        #1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            expv = ROUND ? vecs[i].res_rnd : vecs[i].res_trn;
            pulse_start(vecs[i].din);
            wait_done(lat);
            check($sformatf("lat[%0d]", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("result[%0d]", i), result, expv);
            @(posedge clock);
            #1;
            check($sformatf("done_clear[%0d]", i), {31'd0, done}, 32'd0);
        end

        // Start pulsed mid-conversion of the worst case is ignored
        pulse_start(32'h0000_0001);
        nd = 0;
        first_lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (c == 4) begin
                start = 1'b1;
                dataa = 32'h7FFF_FFFF;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                if (first_lat < 0) first_lat = c;
            end
        end
        check("busy_start_ndone", 32'(nd), 32'd1);
        check("busy_start_lat", 32'(first_lat), 32'd12);
        check("busy_start_result", result, 32'h3000_0000);

        // clk_en low for 5 cycles during NORM stretches latency by 5
        pulse_start(32'h6EC1_BCCD);
        clk_en = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        clk_en = 1'b1;
        wait_done(lat);
        check("freeze_lat", 32'(lat + 5), 32'd8);
        check("freeze_result", result, ROUND ? 32'h3F5D_837A : 32'h3F5D_8379);

        // done holds while clk_en is low, clears on the next enabled edge
        clk_en = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("done_hold", {31'd0, done}, 32'd1);
        clk_en = 1'b1;
        @(posedge clock);
        #1;
        check("done_hold_clear", {31'd0, done}, 32'd0);

        // start coinciding with done is ignored
        pulse_start(32'h8000_0000);
        wait_done(lat);
        check("dstart_lat", 32'(lat), 32'd2);
        start = 1'b1;
        dataa = 32'h7FFF_FFFF;
        @(posedge clock);
        #1;
        start = 1'b0;
        count_dones(15, nd);
        check("dstart_ndone", 32'(nd), 32'd0);
        check("dstart_result", result, 32'hBF80_0000);

        // aclr during NORM aborts the conversion
        pulse_start(32'h0000_0001);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        aclr = 1'b1;
        #1;
        check("abort_result", result, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(posedge clock);
        #1;
        aclr = 1'b0;
        count_dones(15, nd);
        check("abort_ndone", 32'(nd), 32'd0);
        pulse_start(32'h6EC1_BCCD);
        wait_done(lat);
        check("post_abort_lat", 32'(lat), 32'd3);
        check("post_abort_result", result, ROUND ? 32'h3F5D_837A : 32'h3F5D_8379);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
